// File: rtl/alu_pkg.sv
// Shared constants, opcode enum and buffer entry type for the ALU operand issue stage.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int TAG_W  = 4;

    typedef enum logic [OP_W-1:0] {
        ADD = 4'b0000,
        SUB = 4'b0001,
        AND = 4'b0010,
        OR  = 4'b0011,
        XOR = 4'b0100,
        NOR = 4'b0101,
        SLL = 4'b0110,
        SRL = 4'b0111,
        SRA = 4'b1000,
        EQ  = 4'b1001,
        LT  = 4'b1010
    } alu_op_e;

    localparam logic [OP_W-1:0] OP_MAX = 4'b1010;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } buf_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
        logic              fwd_a;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    // Opcodes above OP_MAX make the ALU return zero.
    function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
        return (op > OP_MAX);
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready buffer of operation entries; entry 0 is the head.
// in_ready is a pure state decode so there is no path from out_ready.
module alu_skid_buf
    import alu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    output logic   in_ready,
    input  entry_t in_entry,
    output logic   out_valid,
    input  logic   out_ready,
    output entry_t head
);

    buf_state_e state_q, state_d;
    entry_t     e0_q, e0_d;
    entry_t     e1_q, e1_d;
    logic       push_s, pop_s;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign head      = e0_q;
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Occupancy and entry update; the head keeps its last value when the buffer drains.
    always_comb begin
        state_d = state_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        case (state_q)
            EMPTY: begin
                if (push_s) begin
                    state_d = ONE;
                    e0_d    = in_entry;
                end else begin
                    state_d = EMPTY;
                end
            end
            ONE: begin
                if (push_s && pop_s) begin
                    e0_d = in_entry;
                end else if (push_s) begin
                    state_d = FULL;
                    e1_d    = in_entry;
                end else if (pop_s) begin
                    state_d = EMPTY;
                end else begin
                    state_d = ONE;
                end
            end
            FULL: begin
                if (pop_s) begin
                    state_d = ONE;
                    e0_d    = e1_q;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Buffer state and entry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            e0_q    <= '{default: 1'b0};
            e1_q    <= '{default: 1'b0};
        end else begin
            state_q <= state_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered issue stage feeding the 32-bit ALU: skid buffer, sequence tags,
// illegal-opcode flag and optional Result-to-A forwarding (ALU_OPERAND_FWD_EN).
module alu_operand_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] In_A,
    input  logic [DATA_W-1:0] In_B,
    input  logic [OP_W-1:0]   In_Op_Code,
    input  logic              In_Fwd_A,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [OP_W-1:0]   Op_Code,
    output logic [TAG_W-1:0]  Out_Tag,
    output logic              Out_Illegal,
    input  logic [DATA_W-1:0] Result
);

    entry_t           in_entry_s;
    entry_t           head_s;
    logic             buf_in_ready_s;
    logic             buf_out_valid_s;
    logic             push_s;
    logic             pop_s;
    logic [TAG_W-1:0] tag_q, tag_d;

    assign in_entry_s = '{a: In_A, b: In_B, op: In_Op_Code, fwd_a: In_Fwd_A, tag: tag_q};
    assign push_s     = In_Valid && buf_in_ready_s;
    assign pop_s      = buf_out_valid_s && Out_Ready;

    alu_skid_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (In_Valid),
        .in_ready  (buf_in_ready_s),
        .in_entry  (in_entry_s),
        .out_valid (buf_out_valid_s),
        .out_ready (Out_Ready),
        .head      (head_s)
    );

    assign In_Ready    = buf_in_ready_s;
    assign Out_Valid   = buf_out_valid_s;
    assign B           = head_s.b;
    assign Op_Code     = head_s.op;
    assign Out_Tag     = head_s.tag;
    assign Out_Illegal = is_illegal_op(head_s.op);

    // Tag advances on every accepted packet and wraps naturally.
    always_comb begin
        tag_d = tag_q;
        if (push_s) begin
            tag_d = tag_q + {{(TAG_W-1){1'b0}}, 1'b1};
        end else begin
            tag_d = tag_q;
        end
    end

    // Tag counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= {TAG_W{1'b0}};
        end else begin
            tag_q <= tag_d;
        end
    end

`ifdef ALU_OPERAND_FWD_EN
    logic [DATA_W-1:0] last_result_q, last_result_d;

    // Capture the ALU output of the op leaving the head.
    always_comb begin
        last_result_d = last_result_q;
        if (pop_s) begin
            last_result_d = Result;
        end else begin
            last_result_d = last_result_q;
        end
    end

    // Forwarded-result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_result_q <= {DATA_W{1'b0}};
        end else begin
            last_result_q <= last_result_d;
        end
    end

    // Operand A source select.
    always_comb begin
        A = head_s.a;
        if (head_s.fwd_a) begin
            A = last_result_q;
        end else begin
            A = head_s.a;
        end
    end
`else
    logic unused_fwd_s;

    assign unused_fwd_s = ^{Result, head_s.fwd_a};
    assign A            = head_s.a;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Table-driven bench for alu_operand_stage; honours ALU_OPERAND_FWD_EN when defined.
module tb_alu_operand_stage;

`ifdef ALU_OPERAND_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_op;
    logic        in_fwd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a_o;
    logic [31:0] b_o;
    logic [3:0]  op_o;
    logic [3:0]  tag_o;
    logic        ill_o;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    alu_operand_stage dut (
        .clk         (clk),
        .rst         (rst),
        .In_Valid    (in_valid),
        .In_Ready    (in_ready),
        .In_A        (in_a),
        .In_B        (in_b),
        .In_Op_Code  (in_op),
        .In_Fwd_A    (in_fwd),
        .Out_Valid   (out_valid),
        .Out_Ready   (out_ready),
        .A           (a_o),
        .B           (b_o),
        .Op_Code     (op_o),
        .Out_Tag     (tag_o),
        .Out_Illegal (ill_o),
        .Result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic [31:0] ib;
        logic [3:0]  iop;
        logic        ifwd;
        logic        ordy;
        logic [31:0] res;
        logic        eov;
        logic        eir;
        logic [31:0] ea_plain;
        logic [31:0] ea_fwd;
        logic [31:0] eb;
        logic [3:0]  eop;
        logic [3:0]  etag;
        logic        eill;
        logic        cd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                                input logic [3:0] iop, input logic ifwd, input logic ordy,
                                input logic [31:0] res, input logic eov, input logic eir,
                                input logic [31:0] ea_plain, input logic [31:0] ea_fwd,
                                input logic [31:0] eb, input logic [3:0] eop,
                                input logic [3:0] etag, input logic eill, input logic cd);
        vec_t v;
        v.iv = iv; v.ia = ia; v.ib = ib; v.iop = iop; v.ifwd = ifwd; v.ordy = ordy;
        v.res = res; v.eov = eov; v.eir = eir; v.ea_plain = ea_plain; v.ea_fwd = ea_fwd;
        v.eb = eb; v.eop = eop; v.etag = etag; v.eill = eill; v.cd = cd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic eov, input logic eir, input logic [31:0] ea,
                           input logic [31:0] eb, input logic [3:0] eop, input logic [3:0] etag,
                           input logic eill, input logic cd);
        chk({nm, ".out_valid"}, {31'd0, out_valid}, {31'd0, eov});
        chk({nm, ".in_ready"}, {31'd0, in_ready}, {31'd0, eir});
        if (cd) begin
            chk({nm, ".A"}, a_o, ea);
            chk({nm, ".B"}, b_o, eb);
            chk({nm, ".op"}, {28'd0, op_o}, {28'd0, eop});
            chk({nm, ".tag"}, {28'd0, tag_o}, {28'd0, etag});
            chk({nm, ".illegal"}, {31'd0, ill_o}, {31'd0, eill});
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [3:0] iop, input logic ifwd, input logic ordy,
                         input logic [31:0] res);
        in_valid  = iv;
        in_a      = ia;
        in_b      = ib;
        in_op     = iop;
        in_fwd    = ifwd;
        out_ready = ordy;
        result    = res;
    endtask

    initial begin
        // single push/pop
        vq.push_back(mk(1'b1, 32'd5,  32'd3,  4'd0,  1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd5,  32'd5,  32'd3,  4'd0,  4'd0, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 32'd0,  32'd0,  4'd0,  1'b0, 1'b1, 32'd0,   1'b0, 1'b1, 32'd5,  32'd5,  32'd3,  4'd0,  4'd0, 1'b0, 1'b1));
        // back-pressure: fill, block third push, drain
        vq.push_back(mk(1'b1, 32'd10, 32'd20, 4'd1,  1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd10, 32'd10, 32'd20, 4'd1,  4'd1, 1'b0, 1'b1));
        vq.push_back(mk(1'b1, 32'd11, 32'd21, 4'd2,  1'b0, 1'b0, 32'd0,   1'b1, 1'b0, 32'd10, 32'd10, 32'd20, 4'd1,  4'd1, 1'b0, 1'b1));
        vq.push_back(mk(1'b1, 32'd12, 32'd22, 4'd3,  1'b0, 1'b0, 32'd0,   1'b1, 1'b0, 32'd10, 32'd10, 32'd20, 4'd1,  4'd1, 1'b0, 1'b1));
        vq.push_back(mk(1'b1, 32'd12, 32'd22, 4'd3,  1'b0, 1'b1, 32'd0,   1'b1, 1'b1, 32'd11, 32'd11, 32'd21, 4'd2,  4'd2, 1'b0, 1'b1));
        vq.push_back(mk(1'b1, 32'd12, 32'd22, 4'd3,  1'b0, 1'b0, 32'd0,   1'b1, 1'b0, 32'd11, 32'd11, 32'd21, 4'd2,  4'd2, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 32'd0,  32'd0,  4'd0,  1'b0, 1'b1, 32'd0,   1'b1, 1'b1, 32'd12, 32'd12, 32'd22, 4'd3,  4'd3, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 32'd0,  32'd0,  4'd0,  1'b0, 1'b1, 32'd0,   1'b0, 1'b1, 32'd12, 32'd12, 32'd22, 4'd3,  4'd3, 1'b0, 1'b1));
        // illegal opcode, then boundary opcode 4'b1010 via simultaneous push/pop
        vq.push_back(mk(1'b1, 32'd1,  32'd2,  4'd12, 1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd1,  32'd1,  32'd2,  4'd12, 4'd4, 1'b1, 1'b1));
        vq.push_back(mk(1'b1, 32'd3,  32'd4,  4'd10, 1'b0, 1'b1, 32'd0,   1'b1, 1'b1, 32'd3,  32'd3,  32'd4,  4'd10, 4'd5, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 32'd0,  32'd0,  4'd0,  1'b0, 1'b1, 32'd0,   1'b0, 1'b1, 32'd3,  32'd3,  32'd4,  4'd10, 4'd5, 1'b0, 1'b1));
        // forwarding from ONE: ADD 7+1 returns 8, next op forwards it
        vq.push_back(mk(1'b1, 32'd7,  32'd1,  4'd0,  1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd7,  32'd7,  32'd1,  4'd0,  4'd6, 1'b0, 1'b1));
        vq.push_back(mk(1'b1, 32'd99, 32'd2,  4'd0,  1'b1, 1'b1, 32'd8,   1'b1, 1'b1, 32'd99, 32'd8,  32'd2,  4'd0,  4'd7, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 32'd0,  32'd0,  4'd0,  1'b0, 1'b1, 32'd8,   1'b0, 1'b1, 32'd99, 32'd8,  32'd2,  4'd0,  4'd7, 1'b0, 1'b1));
        // forwarding from FULL: entry 1 shifts to head and sees the new result
        vq.push_back(mk(1'b1, 32'd20, 32'd0,  4'd0,  1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd20, 32'd20, 32'd0,  4'd0,  4'd8, 1'b0, 1'b1));
        vq.push_back(mk(1'b1, 32'd55, 32'd5,  4'd0,  1'b1, 1'b0, 32'd0,   1'b1, 1'b0, 32'd20, 32'd20, 32'd0,  4'd0,  4'd8, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 32'd0,  32'd0,  4'd0,  1'b0, 1'b1, 32'd77,  1'b1, 1'b1, 32'd55, 32'd77, 32'd5,  4'd0,  4'd9, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 32'd0,  32'd0,  4'd0,  1'b0, 1'b1, 32'd100, 1'b0, 1'b1, 32'd0,  32'd0,  32'd0,  4'd0,  4'd0, 1'b0, 1'b0));

        rst = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
        #1 rst = 1'b1;
        #1 chk_all("reset", 1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].iv, vq[i].ia, vq[i].ib, vq[i].iop, vq[i].ifwd, vq[i].ordy, vq[i].res);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vq[i].eov, vq[i].eir,
                    FWD ? vq[i].ea_fwd : vq[i].ea_plain, vq[i].eb, vq[i].eop,
                    vq[i].etag, vq[i].eill, vq[i].cd);
        end

        // fill to FULL, then reset asynchronously mid-cycle
        drive(1'b1, 32'd1, 32'd1, 4'd0, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #1 drive(1'b1, 32'd2, 32'd2, 4'd0, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #1 chk_all("full_before_rst", 1'b1, 1'b0, 32'd1, 32'd1, 4'd0, 4'd10, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
        #2 rst = 1'b1;
        #1 chk_all("rst_while_full", 1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        #2 rst = 1'b0;

        // streaming: one issue per cycle, tags 0..15 then 0..3
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'd100 + 32'(k), 32'(k), 4'(k % 11), 1'b0, 1'b1, 32'd0);
            @(posedge clk);
            #1;
            chk_all($sformatf("stream%0d", k), 1'b1, 1'b1, 32'd100 + 32'(k), 32'(k),
                    4'(k % 11), 4'(k % 16), 1'b0, 1'b1);
        end
        drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 32'd0);
        @(posedge clk);
        #1 chk_all("stream_drain", 1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
